// File: rtl/unidad_control_mc.sv
// Multicycle control unit for the microc datapath.
// Two-step instruction flow: FETCH waits on instruction memory and latches
// the opcode, EXEC decodes it for exactly one cycle.  A return-address-stack
// occupancy counter guards jal/ret, and HALT/ERROR are terminal until reset.

module unidad_control_mc #(
    parameter int OPW         = 6,
    parameter int STACK_DEPTH = 4,
    parameter int STRICT      = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [OPW-1:0]               opcode,
    input  logic                         z,
    input  logic                         imem_ready,
    output logic                         s_inc,
    output logic                         s_inm,
    output logic                         we3,
    output logic                         wez,
    output logic [2:0]                   op,
    output logic                         pc_we,
    output logic                         push,
    output logic                         pop,
    output logic                         s_ret,
    output logic                         halted,
    output logic                         error,
    output logic [1:0]                   err_code,
    output logic [$clog2(STACK_DEPTH):0] sp
);

    localparam int SPW = $clog2(STACK_DEPTH) + 1;
    localparam logic [SPW-1:0] SP_ONE  = SPW'(1);
    localparam logic [SPW-1:0] SP_FULL = SPW'(STACK_DEPTH);
    localparam logic [SPW-1:0] SP_NONE = SPW'(0);

    localparam logic [1:0] ERR_NONE      = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL   = 2'b01;
    localparam logic [1:0] ERR_OVERFLOW  = 2'b10;
    localparam logic [1:0] ERR_UNDERFLOW = 2'b11;

    typedef enum logic [1:0] {
        ST_FETCH = 2'b00,
        ST_EXEC  = 2'b01,
        ST_HALT  = 2'b10,
        ST_ERROR = 2'b11
    } state_t;

    typedef enum logic [3:0] {
        K_ALU  = 4'd0,
        K_NOP  = 4'd1,
        K_LI   = 4'd2,
        K_J    = 4'd3,
        K_JZ   = 4'd4,
        K_JNZ  = 4'd5,
        K_JAL  = 4'd6,
        K_RET  = 4'd7,
        K_HALT = 4'd8,
        K_ILL  = 4'd9
    } kind_t;

    // Classify the six decoded opcode bits into an instruction kind.
    function automatic kind_t decode_kind(input logic [5:0] d);
        kind_t k;
        if (d[5] == 1'b1) begin
            k = K_ALU;
        end else if (d[5:2] == 4'b0001) begin
            k = K_LI;
        end else begin
            case (d)
                6'b000000: k = K_NOP;
                6'b010000: k = K_J;
                6'b010001: k = K_JZ;
                6'b010010: k = K_JNZ;
                6'b010011: k = K_JAL;
                6'b010100: k = K_RET;
                6'b010101: k = K_HALT;
                default:   k = K_ILL;
            endcase
        end
        return k;
    endfunction

    state_t         state_r, state_s;
    logic [5:0]     ir_r;
    logic [SPW-1:0] sp_r, sp_s;
    logic           error_r, error_s;
    logic [1:0]     err_code_r, err_code_s;
    logic           load_ir_s;
    kind_t          kind_s;

    logic           s_inc_s, s_inm_s, we3_s, wez_s, pc_we_s, push_s, pop_s, s_ret_s;
    logic [2:0]     op_s;

    // Reserved low opcode bits are intentionally ignored by the decoder.
    logic           unused_opcode_s;
    assign unused_opcode_s = ^opcode;

    assign kind_s = decode_kind(ir_r);

    // State, instruction register, stack occupancy and sticky error registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_FETCH;
            ir_r       <= 6'b000000;
            sp_r       <= SP_NONE;
            error_r    <= 1'b0;
            err_code_r <= ERR_NONE;
        end else begin
            state_r    <= state_s;
            sp_r       <= sp_s;
            error_r    <= error_s;
            err_code_r <= err_code_s;
            if (load_ir_s) begin
                ir_r <= opcode[OPW-1:OPW-6];
            end else begin
                ir_r <= ir_r;
            end
        end
    end

    // Next-state logic and EXEC-cycle strobe decode (strobes idle elsewhere).
    always_comb begin
        state_s    = state_r;
        sp_s       = sp_r;
        error_s    = error_r;
        err_code_s = err_code_r;
        load_ir_s  = 1'b0;
        s_inc_s    = 1'b0;
        s_inm_s    = 1'b0;
        we3_s      = 1'b0;
        wez_s      = 1'b0;
        op_s       = 3'b000;
        pc_we_s    = 1'b0;
        push_s     = 1'b0;
        pop_s      = 1'b0;
        s_ret_s    = 1'b0;

        case (state_r)
            ST_FETCH: begin
                if (imem_ready) begin
                    load_ir_s = 1'b1;
                    state_s   = ST_EXEC;
                end else begin
                    state_s   = ST_FETCH;
                end
            end

            ST_EXEC: begin
                state_s = ST_FETCH;
                pc_we_s = 1'b1;
                case (kind_s)
                    K_ALU: begin
                        s_inc_s = 1'b1;
                        we3_s   = 1'b1;
                        wez_s   = 1'b1;
                        op_s    = ir_r[4:2];
                    end
                    K_NOP: begin
                        s_inc_s = 1'b1;
                    end
                    K_LI: begin
                        s_inc_s = 1'b1;
                        s_inm_s = 1'b1;
                        we3_s   = 1'b1;
                    end
                    K_J: begin
                        s_inc_s = 1'b0;
                    end
                    K_JZ: begin
                        s_inc_s = ~z;
                    end
                    K_JNZ: begin
                        s_inc_s = z;
                    end
                    K_JAL: begin
                        if (sp_r == SP_FULL) begin
                            // Stack full: suppress the call entirely.
                            pc_we_s    = 1'b0;
                            error_s    = 1'b1;
                            err_code_s = ERR_OVERFLOW;
                            state_s    = ST_ERROR;
                        end else begin
                            push_s = 1'b1;
                            sp_s   = sp_r + SP_ONE;
                        end
                    end
                    K_RET: begin
                        if (sp_r == SP_NONE) begin
                            // Nothing to return to: suppress the return.
                            pc_we_s    = 1'b0;
                            error_s    = 1'b1;
                            err_code_s = ERR_UNDERFLOW;
                            state_s    = ST_ERROR;
                        end else begin
                            s_ret_s = 1'b1;
                            pop_s   = 1'b1;
                            sp_s    = sp_r - SP_ONE;
                        end
                    end
                    K_HALT: begin
                        pc_we_s = 1'b0;
                        state_s = ST_HALT;
                    end
                    K_ILL: begin
                        if (STRICT != 0) begin
                            pc_we_s    = 1'b0;
                            error_s    = 1'b1;
                            err_code_s = ERR_ILLEGAL;
                            state_s    = ST_ERROR;
                        end else begin
                            s_inc_s = 1'b1;
                        end
                    end
                    default: begin
                        pc_we_s = 1'b0;
                        state_s = ST_FETCH;
                    end
                endcase
            end

            ST_HALT: begin
                state_s = ST_HALT;
            end

            ST_ERROR: begin
                state_s = ST_ERROR;
            end

            default: begin
                state_s = ST_FETCH;
            end
        endcase
    end

    assign s_inc    = s_inc_s;
    assign s_inm    = s_inm_s;
    assign we3      = we3_s;
    assign wez      = wez_s;
    assign op       = op_s;
    assign pc_we    = pc_we_s;
    assign push     = push_s;
    assign pop      = pop_s;
    assign s_ret    = s_ret_s;
    assign halted   = (state_r == ST_HALT);
    assign error    = error_r;
    assign err_code = err_code_r;
    assign sp       = sp_r;

    unidad_control_mc_checker #(
        .STACK_DEPTH (STACK_DEPTH)
    ) u_checker (
        .clk      (clk),
        .reset    (reset),
        .push     (push_s),
        .pop      (pop_s),
        .pc_we    (pc_we_s),
        .halted   (halted),
        .error    (error_r),
        .err_code (err_code_r),
        .sp       (sp_r)
    );

endmodule

// Invariant checks on the control unit outputs.
module unidad_control_mc_checker #(
    parameter int STACK_DEPTH = 4
) (
    input logic                         clk,
    input logic                         reset,
    input logic                         push,
    input logic                         pop,
    input logic                         pc_we,
    input logic                         halted,
    input logic                         error,
    input logic [1:0]                   err_code,
    input logic [$clog2(STACK_DEPTH):0] sp
);

    localparam int SPW = $clog2(STACK_DEPTH) + 1;

    // Stack and halt invariants, checked outside reset.
    always @(posedge clk) begin
        if (!reset) begin
            assert (!(push && pop));
            assert (sp <= SPW'(STACK_DEPTH));
            assert (!(halted && pc_we));
            assert (error || (err_code == 2'b00));
        end
    end

endmodule

// File: tb/tb_unidad_control_mc.sv
// Bench for unidad_control_mc: two instances (strict/depth 2/OPW 6 and
// lenient/depth 4/OPW 8) share the stimulus; a per-cycle compare process
// checks both against an instruction-level model, and directed literal
// checks pin the model.

module tb_unidad_control_mc;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [7:0] b_opcode;
    logic       z;
    logic       imem_ready;

    always #5 clk = ~clk;

    assign b_opcode = {opcode, 2'b10};

    logic       a_s_inc, a_s_inm, a_we3, a_wez, a_pc_we, a_push, a_pop, a_s_ret;
    logic       a_halted, a_error;
    logic [2:0] a_op;
    logic [1:0] a_err_code;
    logic [1:0] a_sp;

    logic       b_s_inc, b_s_inm, b_we3, b_wez, b_pc_we, b_push, b_pop, b_s_ret;
    logic       b_halted, b_error;
    logic [2:0] b_op;
    logic [1:0] b_err_code;
    logic [2:0] b_sp;

    unidad_control_mc #(.OPW(6), .STACK_DEPTH(2), .STRICT(1)) u_dut_a (
        .clk(clk), .reset(reset), .opcode(opcode), .z(z), .imem_ready(imem_ready),
        .s_inc(a_s_inc), .s_inm(a_s_inm), .we3(a_we3), .wez(a_wez), .op(a_op),
        .pc_we(a_pc_we), .push(a_push), .pop(a_pop), .s_ret(a_s_ret),
        .halted(a_halted), .error(a_error), .err_code(a_err_code), .sp(a_sp)
    );

    unidad_control_mc #(.OPW(8), .STACK_DEPTH(4), .STRICT(0)) u_dut_b (
        .clk(clk), .reset(reset), .opcode(b_opcode), .z(z), .imem_ready(imem_ready),
        .s_inc(b_s_inc), .s_inm(b_s_inm), .we3(b_we3), .wez(b_wez), .op(b_op),
        .pc_we(b_pc_we), .push(b_push), .pop(b_pop), .s_ret(b_s_ret),
        .halted(b_halted), .error(b_error), .err_code(b_err_code), .sp(b_sp)
    );

    // Strobe vector order: s_inc s_inm we3 wez op[2:0] pc_we push pop s_ret
    logic [10:0] a_vec, b_vec;
    assign a_vec = {a_s_inc, a_s_inm, a_we3, a_wez, a_op, a_pc_we, a_push, a_pop, a_s_ret};
    assign b_vec = {b_s_inc, b_s_inm, b_we3, b_wez, b_op, b_pc_we, b_push, b_pop, b_s_ret};

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- instruction-level model ----------------
    // phase: 0 waiting for instruction, 1 executing, 2 halted, 3 faulted
    typedef struct packed {
        logic [1:0] phase;
        logic [5:0] ir;
        logic [3:0] sp;
        logic       err;
        logic [1:0] code;
    } mstate_t;

    mstate_t m0 = '0;
    mstate_t m1 = '0;

    // 0 alu,1 nop,2 li,3 j,4 jz,5 jnz,6 jal,7 ret,8 halt; illegal becomes 9
    // (strict) or nop (lenient)
    function automatic int kind_of(input logic [5:0] d, input bit strict);
        if (d[5]) return 0;
        if (d == 6'b000000) return 1;
        if (d[5:2] == 4'b0001) return 2;
        if (d == 6'b010000) return 3;
        if (d == 6'b010001) return 4;
        if (d == 6'b010010) return 5;
        if (d == 6'b010011) return 6;
        if (d == 6'b010100) return 7;
        if (d == 6'b010101) return 8;
        return strict ? 9 : 1;
    endfunction

    function automatic logic [10:0] exp_strobes(input mstate_t s, input logic zz,
                                                input int depth, input bit strict);
        logic inc = 1'b0, inm = 1'b0, w3 = 1'b0, wz = 1'b0;
        logic pcw = 1'b1, pu = 1'b0, po = 1'b0, sr = 1'b0;
        logic [2:0] o = 3'b000;
        if (s.phase != 2'd1) return 11'b0;
        case (kind_of(s.ir, strict))
            0: begin inc = 1'b1; w3 = 1'b1; wz = 1'b1; o = s.ir[4:2]; end
            1: inc = 1'b1;
            2: begin inc = 1'b1; inm = 1'b1; w3 = 1'b1; end
            3: inc = 1'b0;
            4: inc = ~zz;
            5: inc = zz;
            6: if (int'(s.sp) == depth) pcw = 1'b0; else pu = 1'b1;
            7: if (s.sp == 4'd0) pcw = 1'b0; else begin po = 1'b1; sr = 1'b1; end
            default: pcw = 1'b0;
        endcase
        return {inc, inm, w3, wz, o, pcw, pu, po, sr};
    endfunction

    function automatic mstate_t model_next(input mstate_t s, input logic rst, input logic rdy,
                                           input logic [5:0] opc, input int depth, input bit strict);
        mstate_t n = s;
        if (rst) return '0;
        if (s.phase == 2'd0) begin
            if (rdy) begin n.ir = opc; n.phase = 2'd1; end
        end else if (s.phase == 2'd1) begin
            n.phase = 2'd0;
            case (kind_of(s.ir, strict))
                6: if (int'(s.sp) == depth) begin n.err = 1'b1; n.code = 2'd2; n.phase = 2'd3; end
                   else n.sp = s.sp + 4'd1;
                7: if (s.sp == 4'd0) begin n.err = 1'b1; n.code = 2'd3; n.phase = 2'd3; end
                   else n.sp = s.sp - 4'd1;
                8: n.phase = 2'd2;
                9: begin n.err = 1'b1; n.code = 2'd1; n.phase = 2'd3; end
                default: n.phase = 2'd0;
            endcase
        end
        return n;
    endfunction

    // Advance the model on every rising edge.
    always @(posedge clk) begin
        m0 <= model_next(m0, reset, imem_ready, opcode, 2, 1'b1);
        m1 <= model_next(m1, reset, imem_ready, opcode, 4, 1'b0);
    end

    // Compare both DUTs against the model on every falling edge.
    always @(negedge clk) begin
        check("a_strobes", 32'(a_vec), 32'(exp_strobes(m0, z, 2, 1'b1)));
        check("a_halted", 32'(a_halted), 32'(m0.phase == 2'd2));
        check("a_error", 32'(a_error), 32'(m0.err));
        check("a_err_code", 32'(a_err_code), 32'(m0.code));
        check("a_sp", 32'(a_sp), 32'(m0.sp));
        check("b_strobes", 32'(b_vec), 32'(exp_strobes(m1, z, 4, 1'b0)));
        check("b_halted", 32'(b_halted), 32'(m1.phase == 2'd2));
        check("b_error", 32'(b_error), 32'(m1.err));
        check("b_err_code", 32'(b_err_code), 32'(m1.code));
        check("b_sp", 32'(b_sp), 32'(m1.sp));
    end

    // ---------------- directed stimulus ----------------
    logic [10:0] ob_a, ob_b;

    task automatic step(input logic rdy, input logic [5:0] opc, input logic zz);
        imem_ready = rdy;
        opcode     = opc;
        z          = zz;
        @(posedge clk);
        #1;
    endtask

    // Fetch one instruction (with z inverted during fetch), then run its
    // EXEC cycle with z=zz, capturing the strobes mid-cycle.
    task automatic exec_instr(input logic [5:0] opc, input logic zz);
        step(1'b1, opc, ~zz);
        imem_ready = 1'b0;
        opcode     = ~opc;
        z          = zz;
        @(negedge clk);
        ob_a = a_vec;
        ob_b = b_vec;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b0, 6'b000000, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        imem_ready = 1'b0;
        opcode     = 6'b000000;
        z          = 1'b0;
        step(1'b0, 6'b000000, 1'b0);
        step(1'b0, 6'b000000, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        check("lit_reset_sp", 32'(a_sp), 32'd0);
        check("lit_reset_err", 32'({a_error, a_err_code, a_halted}), 32'd0);
        check("lit_reset_strobes", 32'(a_vec), 32'd0);
        @(posedge clk);
        #1;

        // ALU op 001
        exec_instr(6'b100100, 1'b0);
        check("lit_alu", 32'(ob_a), 32'(11'b1_0_1_1_001_1_0_0_0));
        @(negedge clk);
        check("lit_refetch_pc_we", 32'(a_pc_we), 32'd0);
        @(posedge clk);
        #1;

        // li after a 3-cycle wait
        for (int i = 0; i < 3; i++) step(1'b0, 6'b000101, 1'b0);
        exec_instr(6'b000101, 1'b0);
        check("lit_li", 32'(ob_a), 32'(11'b1_1_1_0_000_1_0_0_0));

        // conditional and unconditional jumps
        exec_instr(6'b010001, 1'b1);
        check("lit_jz_z1", 32'(ob_a), 32'(11'b0_0_0_0_000_1_0_0_0));
        exec_instr(6'b010001, 1'b0);
        check("lit_jz_z0", 32'(ob_a), 32'(11'b1_0_0_0_000_1_0_0_0));
        exec_instr(6'b010010, 1'b1);
        check("lit_jnz_z1", 32'(ob_a), 32'(11'b1_0_0_0_000_1_0_0_0));
        exec_instr(6'b010000, 1'b0);
        check("lit_j", 32'(ob_a), 32'(11'b0_0_0_0_000_1_0_0_0));

        // stack overflow on the depth-2 instance
        exec_instr(6'b010011, 1'b0);
        check("lit_jal1_push", 32'(ob_a), 32'(11'b0_0_0_0_000_1_1_0_0));
        check("lit_jal1_sp", 32'(a_sp), 32'd1);
        exec_instr(6'b010011, 1'b0);
        check("lit_jal2_sp", 32'(a_sp), 32'd2);
        exec_instr(6'b010011, 1'b0);
        check("lit_jal3_strobes", 32'(ob_a), 32'd0);
        check("lit_jal3_err", 32'({a_error, a_err_code}), 32'(3'b1_10));
        check("lit_b_sp3", 32'(b_sp), 32'd3);
        exec_instr(6'b010100, 1'b0);
        check("lit_ret_in_error_sp", 32'(a_sp), 32'd2);
        check("lit_ret_in_error_strobes", 32'(ob_a), 32'd0);
        check("lit_b_ret", 32'(ob_b), 32'(11'b0_0_0_0_000_1_0_1_1));
        do_reset();
        check("lit_post_reset_sp", 32'(a_sp), 32'd0);
        check("lit_post_reset_err", 32'(a_error), 32'd0);

        // stack underflow
        exec_instr(6'b010100, 1'b0);
        check("lit_ret_underflow", 32'(ob_a), 32'd0);
        check("lit_ret_underflow_code", 32'(a_err_code), 32'(2'b11));
        do_reset();

        // illegal opcode: strict faults, lenient runs as nop
        exec_instr(6'b011000, 1'b0);
        check("lit_ill_strict", 32'(ob_a), 32'd0);
        check("lit_ill_strict_code", 32'({a_error, a_err_code}), 32'(3'b1_01));
        check("lit_ill_lenient", 32'(ob_b), 32'(11'b1_0_0_0_000_1_0_0_0));
        check("lit_ill_lenient_err", 32'(b_error), 32'd0);
        do_reset();

        // halt, then keep offering instructions for 10 cycles
        exec_instr(6'b010101, 1'b0);
        check("lit_halt_strobes", 32'(ob_a), 32'd0);
        for (int i = 0; i < 10; i++) step(1'b1, 6'b100100, 1'b0);
        @(negedge clk);
        check("lit_halted", 32'(a_halted), 32'd1);
        check("lit_halted_pc_we", 32'(a_pc_we), 32'd0);
        @(posedge clk);
        #1;
        do_reset();

        // reset during the EXEC of jal aborts the push
        step(1'b1, 6'b010011, 1'b0);
        reset      = 1'b1;
        imem_ready = 1'b0;
        @(negedge clk);
        check("lit_jal_exec_before_reset", 32'(a_push), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("lit_abort_sp", 32'(a_sp), 32'd0);
        check("lit_abort_fetch", 32'(a_vec), 32'd0);
        @(posedge clk);
        #1;
        exec_instr(6'b000000, 1'b0);
        check("lit_nop_after_abort", 32'(ob_a), 32'(11'b1_0_0_0_000_1_0_0_0));
        check("lit_nop_after_abort_sp", 32'(a_sp), 32'd0);

        step(1'b0, 6'b000000, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
